// File: rtl/uart_tx_fifo.sv
`timescale 1ns/1ps
// Byte FIFO plus Tx_WR/Tx_BUSY write sequencer that feeds UART_transmitter.
// A byte pushed into an empty FIFO reaches Tx_WR 2 cycles later; writes while full are dropped unless a pop coincides.
module uart_tx_fifo #(
    parameter int DEPTH        = 8,
    parameter int ADDR_W       = 3,
    parameter int BUSY_TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [7:0]        wr_data,
    input  logic              clr_ovf,
    input  logic              Tx_BUSY,
    output logic              Tx_WR,
    output logic [7:0]        Tx_DATA,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic              timeout_err
);

    localparam int              TO_W     = $clog2(BUSY_TIMEOUT + 1);
    localparam logic [TO_W-1:0] TO_LAST  = TO_W'(BUSY_TIMEOUT - 1);
    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] CNT_ONE  = (ADDR_W+1)'(1);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_ISSUE     = 2'd1,
        S_WAIT_BUSY = 2'd2,
        S_WAIT_DONE = 2'd3
    } state_t;

    logic [7:0]        mem_q [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              full_q, empty_q;
    logic              ovf_q, ovf_d;
    logic              push, pop, drop;

    state_t            state_q;
    logic              tx_wr_q;
    logic [7:0]        tx_data_q;
    logic              to_err_q;
    logic [TO_W-1:0]   to_cnt_q;
    logic [TO_W-1:0]   to_cnt_inc;

    assign to_cnt_inc = to_cnt_q + TO_W'(1);

    always_comb begin
        pop      = (state_q == S_ISSUE);
        push     = wr_en && (!full_q || pop);
        drop     = wr_en && full_q && !pop;
        wr_ptr_d = push ? wr_ptr_q + ADDR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + ADDR_W'(1) : rd_ptr_q;
        count_d  = count_q;
        if (push && !pop) begin
            count_d = count_q + CNT_ONE;
        end else if (pop && !push) begin
            count_d = count_q - CNT_ONE;
        end
        // A drop in the same cycle as clr_ovf keeps the flag set.
        ovf_d    = drop || (ovf_q && !clr_ovf);
    end

    always_ff @(posedge clk) begin
        if (reset && push) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= (count_d == FULL_CNT);
            empty_q  <= (count_d == '0);
            ovf_q    <= ovf_d;
        end
    end

    // Tx_DATA is loaded on entry to ISSUE so it is valid alongside Tx_WR; rd_ptr advances as ISSUE ends.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            tx_wr_q   <= 1'b0;
            tx_data_q <= 8'h00;
            to_err_q  <= 1'b0;
            to_cnt_q  <= '0;
        end else begin
            tx_wr_q  <= 1'b0;
            to_err_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (!empty_q && !Tx_BUSY) begin
                        state_q   <= S_ISSUE;
                        tx_wr_q   <= 1'b1;
                        tx_data_q <= mem_q[rd_ptr_q];
                    end
                end
                S_ISSUE: begin
                    state_q  <= S_WAIT_BUSY;
                    to_cnt_q <= '0;
                end
                S_WAIT_BUSY: begin
                    if (Tx_BUSY) begin
                        state_q <= S_WAIT_DONE;
                    end else if (to_cnt_inc == TO_LAST) begin
                        state_q  <= S_IDLE;
                        to_err_q <= 1'b1;
                        to_cnt_q <= to_cnt_inc;
                    end else begin
                        to_cnt_q <= to_cnt_inc;
                    end
                end
                S_WAIT_DONE: begin
                    if (!Tx_BUSY) begin
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign Tx_WR       = tx_wr_q;
    assign Tx_DATA     = tx_data_q;
    assign full        = full_q;
    assign empty       = empty_q;
    assign count       = count_q;
    assign overflow    = ovf_q;
    assign timeout_err = to_err_q;

endmodule
